// File: rtl/dut_bridge_pkg.sv
// Shared definitions for the byte-stream to DUT command bridge.
// Contents: command and status encodings, bridge FSM state enum, and helpers that
// compute frame field offsets (MSB-first packing) from the configured widths.
package dut_bridge_pkg;

  typedef enum logic [1:0] {
    CMD_ECHO  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2,
    CMD_TEST  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    STAT_OK      = 2'd0,
    STAT_TIMEOUT = 2'd1,
    STAT_BAD_SEL = 2'd2,
    STAT_CHK_ERR = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_RX,
    S_DEC,
    S_EXEC,
    S_WAIT,
    S_TX
  } state_e;

  // CMD/STATUS field sits at the very top of the frame.
  function automatic int unsigned cmd_lsb(input int unsigned frame_w,
                                          input int unsigned cmds_w);
    return frame_w - cmds_w;
  endfunction

  // SEL directly below CMD.
  function automatic int unsigned sel_lsb(input int unsigned frame_w, input int unsigned cmds_w,
                                          input int unsigned sel_w);
    return frame_w - cmds_w - sel_w;
  endfunction

  // ADR directly below SEL; DATA lives at the LSBs, any gap between is zero-filled.
  function automatic int unsigned adr_lsb(input int unsigned frame_w, input int unsigned cmds_w,
                                          input int unsigned sel_w, input int unsigned adr_w);
    return frame_w - cmds_w - sel_w - adr_w;
  endfunction

endpackage

// File: rtl/dut_frame_bridge_timeout.sv
// bridge_timeout_counter: cycle counter with synchronous clear and saturating expiry flag.
// Ports:
//   i_clk      clock
//   i_rstn     synchronous active-low reset
//   i_clear    restart the count from zero (takes priority over i_en)
//   i_en       count one cycle
//   o_expired  high once LIMIT cycles have been counted; holds until cleared
module bridge_timeout_counter #(
  parameter int unsigned LIMIT = 1024,
  localparam int unsigned CNT_W = $clog2(LIMIT + 1)
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_clear) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/dut_frame_bridge.sv
// dut_frame_bridge: assembles UART bytes into command frames, executes ECHO/WRITE/READ/TEST
// on the selected DUT and streams back a status-tagged response frame.
// Optional feature macro: DUT_FRAME_BRIDGE_CHECKSUM_EN adds a trailing XOR checksum byte to
// every RX and TX frame; a bad RX checksum answers CHK_ERR without executing.
// Ports:
//   CLK_SYS, RSTN            clock, synchronous active-low reset
//   RX_VALID, RX_DATA        received byte strobe and byte (no backpressure)
//   TX_VALID, TX_DATA, TX_READY  response byte stream, valid/ready handshake
//   DUT_START                one-cycle write strobe / start-test pulse
//   DUT_SEL, DUT_ADR, DUT_RnW, DUT_DIN  DUT bus, held between accesses
//   DUT_DOUT, DUT_RDY        DUT read data and done flag
//   BUSY                     high whenever not collecting RX bytes
//   OVERRUN                  sticky, a byte arrived while busy and was dropped
module dut_frame_bridge
  import dut_bridge_pkg::*;
#(
  parameter int unsigned BITWIDTH        = 8,
  parameter int unsigned FRAME_BYTES     = 4,
  parameter int unsigned BITWIDTH_CMDS   = 2,
  parameter int unsigned BITWIDTH_ADR    = 6,
  parameter int unsigned BITWIDTH_DATA   = 16,
  parameter int unsigned NUM_DUT         = 4,
  parameter int unsigned RX_IDLE_TIMEOUT = 100000,
  parameter int unsigned DUT_TIMEOUT     = 1024,
  localparam int unsigned FRAME_W        = BITWIDTH * FRAME_BYTES,
  localparam int unsigned SEL_W          = $clog2(NUM_DUT) + 1
) (
  input  logic                     CLK_SYS,
  input  logic                     RSTN,
  input  logic                     RX_VALID,
  input  logic [BITWIDTH-1:0]      RX_DATA,
  output logic                     TX_VALID,
  output logic [BITWIDTH-1:0]      TX_DATA,
  input  logic                     TX_READY,
  output logic                     DUT_START,
  output logic [SEL_W-1:0]         DUT_SEL,
  output logic [BITWIDTH_ADR-1:0]  DUT_ADR,
  output logic                     DUT_RnW,
  output logic [BITWIDTH_DATA-1:0] DUT_DIN,
  input  logic [BITWIDTH_DATA-1:0] DUT_DOUT,
  input  logic                     DUT_RDY,
  output logic                     BUSY,
  output logic                     OVERRUN
);

`ifdef DUT_FRAME_BRIDGE_CHECKSUM_EN
  localparam int unsigned CHK_BYTES = 1;
`else
  localparam int unsigned CHK_BYTES = 0;
`endif
  localparam int unsigned XFER_BYTES = FRAME_BYTES + CHK_BYTES;
  localparam int unsigned XFER_W     = XFER_BYTES * BITWIDTH;
  localparam int unsigned CNT_W      = $clog2(XFER_BYTES + 1);
  localparam int unsigned RX_OFS     = CHK_BYTES * BITWIDTH;
  localparam int unsigned CMD_LSB    = cmd_lsb(FRAME_W, BITWIDTH_CMDS);
  localparam int unsigned SEL_LSB    = sel_lsb(FRAME_W, BITWIDTH_CMDS, SEL_W);
  localparam int unsigned ADR_LSB    = adr_lsb(FRAME_W, BITWIDTH_CMDS, SEL_W, BITWIDTH_ADR);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(XFER_BYTES - 1);

  if ((BITWIDTH_CMDS + SEL_W + BITWIDTH_ADR + BITWIDTH_DATA > FRAME_W) ||
      (BITWIDTH_CMDS < 2)) begin : g_bad_layout
    $error("dut_frame_bridge: frame fields do not fit FRAME_W");
  end

  state_e r_state, w_state_next;

  logic [XFER_W-1:0]        r_rx_shift;
  logic [CNT_W-1:0]         r_rx_cnt;
  logic [XFER_W-1:0]        r_tx_shift;
  logic [CNT_W-1:0]         r_tx_cnt;
  logic                     r_tx_arm;
  logic                     r_tx_valid;
  logic                     r_dut_start;
  logic [SEL_W-1:0]         r_dut_sel;
  logic [BITWIDTH_ADR-1:0]  r_dut_adr;
  logic                     r_dut_rnw;
  logic [BITWIDTH_DATA-1:0] r_dut_din;
  logic                     r_overrun;

  logic [BITWIDTH_CMDS-1:0] w_cmd;
  logic [SEL_W-1:0]         w_sel;
  logic [BITWIDTH_ADR-1:0]  w_adr;
  logic [BITWIDTH_DATA-1:0] w_data;
  logic                     w_sel_bad;
  logic                     w_chk_bad;
  logic                     w_rx_idle_expired;
  logic                     w_dut_expired;
  logic                     w_resp_load;
  logic                     w_bus_load;
  logic                     w_dut_start;
  status_e                  w_status;
  logic [BITWIDTH_DATA-1:0] w_resp_data;
  logic [FRAME_W-1:0]       w_resp;
  logic [XFER_W-1:0]        w_tx_load;

  // Field decode straight from the RX shift register; it is frozen outside S_RX.
  assign w_cmd     = r_rx_shift[RX_OFS + CMD_LSB +: BITWIDTH_CMDS];
  assign w_sel     = r_rx_shift[RX_OFS + SEL_LSB +: SEL_W];
  assign w_adr     = r_rx_shift[RX_OFS + ADR_LSB +: BITWIDTH_ADR];
  assign w_data    = r_rx_shift[RX_OFS +: BITWIDTH_DATA];
  assign w_sel_bad = (32'(w_sel) >= NUM_DUT);

`ifdef DUT_FRAME_BRIDGE_CHECKSUM_EN
  function automatic logic [BITWIDTH-1:0] xor_bytes(input logic [FRAME_W-1:0] f);
    logic [BITWIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < int'(FRAME_BYTES); i++) begin
      acc = acc ^ f[i*BITWIDTH +: BITWIDTH];
    end
    return acc;
  endfunction

  assign w_chk_bad = (xor_bytes(r_rx_shift[XFER_W-1 -: FRAME_W]) != r_rx_shift[BITWIDTH-1:0]);
  assign w_tx_load = {w_resp, xor_bytes(w_resp)};
`else
  assign w_chk_bad = 1'b0;
  assign w_tx_load = w_resp;
`endif

  // Idle timer runs only while a partial frame is pending; any byte restarts it.
  bridge_timeout_counter #(
    .LIMIT(RX_IDLE_TIMEOUT)
  ) u_rx_idle_timeout (
    .i_clk    (CLK_SYS),
    .i_rstn   (RSTN),
    .i_clear  ((r_state != S_RX) || RX_VALID || (r_rx_cnt == '0)),
    .i_en     (1'b1),
    .o_expired(w_rx_idle_expired)
  );

  bridge_timeout_counter #(
    .LIMIT(DUT_TIMEOUT)
  ) u_dut_timeout (
    .i_clk    (CLK_SYS),
    .i_rstn   (RSTN),
    .i_clear  (r_state != S_WAIT),
    .i_en     (1'b1),
    .o_expired(w_dut_expired)
  );

  always_ff @(posedge CLK_SYS) begin
    if (!RSTN) begin
      r_state <= S_RX;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_resp_load  = 1'b0;
    w_bus_load   = 1'b0;
    w_dut_start  = 1'b0;
    w_status     = STAT_OK;
    w_resp_data  = '0;
    unique case (r_state)
      S_RX: begin
        if (RX_VALID && (r_rx_cnt == LAST_IDX)) w_state_next = S_DEC;
      end
      S_DEC: begin
        if (w_chk_bad) begin
          w_status     = STAT_CHK_ERR;
          w_resp_load  = 1'b1;
          w_state_next = S_TX;
        end else if (w_sel_bad) begin
          w_status     = STAT_BAD_SEL;
          w_resp_load  = 1'b1;
          w_state_next = S_TX;
        end else begin
          w_state_next = S_EXEC;
          // Bus registers update here so they are valid throughout S_EXEC.
          w_bus_load   = (w_cmd != BITWIDTH_CMDS'(CMD_ECHO));
          w_dut_start  = (w_cmd == BITWIDTH_CMDS'(CMD_WRITE)) ||
                         (w_cmd == BITWIDTH_CMDS'(CMD_TEST));
        end
      end
      S_EXEC: begin
        if (w_cmd == BITWIDTH_CMDS'(CMD_TEST)) begin
          w_state_next = S_WAIT;
        end else begin
          w_resp_data  = (w_cmd == BITWIDTH_CMDS'(CMD_READ)) ? DUT_DOUT : w_data;
          w_resp_load  = 1'b1;
          w_state_next = S_TX;
        end
      end
      S_WAIT: begin
        // DUT_RDY checked first so a ready on the expiry cycle still reports OK.
        if (DUT_RDY) begin
          w_resp_data  = DUT_DOUT;
          w_resp_load  = 1'b1;
          w_state_next = S_TX;
        end else if (w_dut_expired) begin
          w_status     = STAT_TIMEOUT;
          w_resp_load  = 1'b1;
          w_state_next = S_TX;
        end
      end
      S_TX: begin
        if (r_tx_valid && TX_READY && (r_tx_cnt == LAST_IDX)) w_state_next = S_RX;
      end
      default: w_state_next = S_RX;
    endcase
  end

  always_comb begin
    w_resp = '0;
    w_resp[CMD_LSB +: BITWIDTH_CMDS] = BITWIDTH_CMDS'(w_status);
    w_resp[SEL_LSB +: SEL_W]         = w_sel;
    w_resp[ADR_LSB +: BITWIDTH_ADR]  = w_adr;
    w_resp[0 +: BITWIDTH_DATA]       = w_resp_data;
  end

  always_ff @(posedge CLK_SYS) begin
    if (!RSTN) begin
      r_rx_shift  <= '0;
      r_rx_cnt    <= '0;
      r_tx_shift  <= '0;
      r_tx_cnt    <= '0;
      r_tx_arm    <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_dut_start <= 1'b0;
      r_dut_sel   <= '0;
      r_dut_adr   <= '0;
      r_dut_rnw   <= 1'b0;
      r_dut_din   <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (r_state == S_RX) begin
        // A byte beats a simultaneous idle expiry.
        if (RX_VALID) begin
          r_rx_shift <= {r_rx_shift[XFER_W-BITWIDTH-1:0], RX_DATA};
          r_rx_cnt   <= (r_rx_cnt == LAST_IDX) ? '0 : r_rx_cnt + CNT_W'(1);
        end else if (w_rx_idle_expired) begin
          r_rx_cnt <= '0;
        end
      end else if (RX_VALID) begin
        r_overrun <= 1'b1;
      end

      r_dut_start <= w_dut_start;
      if (w_bus_load) begin
        r_dut_sel <= w_sel;
        r_dut_adr <= w_adr;
        r_dut_rnw <= (w_cmd == BITWIDTH_CMDS'(CMD_READ));
        r_dut_din <= w_data;
      end

      // Response is loaded one cycle before TX_VALID rises.
      if (w_resp_load) begin
        r_tx_shift <= w_tx_load;
        r_tx_cnt   <= '0;
        r_tx_arm   <= 1'b1;
      end else if (r_tx_arm) begin
        r_tx_arm   <= 1'b0;
        r_tx_valid <= 1'b1;
      end else if (r_tx_valid && TX_READY) begin
        if (r_tx_cnt == LAST_IDX) begin
          r_tx_valid <= 1'b0;
        end else begin
          r_tx_shift <= {r_tx_shift[XFER_W-BITWIDTH-1:0], BITWIDTH'(0)};
          r_tx_cnt   <= r_tx_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign TX_VALID  = r_tx_valid;
  assign TX_DATA   = r_tx_shift[XFER_W-1 -: BITWIDTH];
  assign DUT_START = r_dut_start;
  assign DUT_SEL   = r_dut_sel;
  assign DUT_ADR   = r_dut_adr;
  assign DUT_RnW   = r_dut_rnw;
  assign DUT_DIN   = r_dut_din;
  assign BUSY      = (r_state != S_RX);
  assign OVERRUN   = r_overrun;

endmodule
